rr_arbiter4: RTL
================

Name: rr_arbiter4

Overview:
Four-requester round-robin arbiter that shares the 4-to-2 encode / 2-to-4 decode path between requesters. Grants are registered one-hot with a matching 2-bit ID. Each tenure is bounded by a hold limit and followed by a fixed one-cycle turnaround. Sits in front of the shared code-conversion datapath and drives its select/enable.

Parameters:
MAX_HOLD, 8, maximum cycles a single grant may be held (legal range 1..255).
CNT_W, 8, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
CLK  input  1  rising-edge clock
RST  input  1  reset, asynchronous, active-high
EN  input  1  arbiter enable; low blocks new grants and ends the current one
REQ  input  4  request vector; bit i = requester i
GNT  output  4  registered one-hot grant
GNT_ID  output  2  binary index of the granted requester (valid when BUSY=1)
BUSY  output  1  high while any grant is active (equals OR of GNT)

Behaviour:
- Reset (async, RST=1): state IDLE, GNT=0000, GNT_ID=00, BUSY=0, PRI=0 (requester 0 highest priority), hold count=0.
- Arbitration (comb): first i with REQ[i]=1, searching PRI, PRI+1, ... mod 4.
- States: IDLE, GRANT, TURN.
- IDLE: if EN=1 and REQ!=0, the winner is registered at the next edge: GNT=onehot(w), GNT_ID=w, count=0, go to GRANT. Latency is 1 cycle from a sampled REQ to GNT. Otherwise stay in IDLE.
- GRANT: at each edge, release if any of the following holds: REQ[GNT_ID]=0; EN=0; count==MAX_HOLD-1. Otherwise increment count and keep the grant.
- On release: GNT=0000, BUSY=0, PRI=(GNT_ID+1) mod 4, go to TURN. GNT_ID keeps its last value.
- A grant therefore spans 1..MAX_HOLD cycles.
- TURN: exactly one cycle with GNT=0. Arbitration is evaluated with the updated PRI.
  - If EN=1 and REQ!=0, go to GRANT with the new winner.
  - Otherwise go to IDLE.
- Back-to-back grants always have exactly one idle cycle between them.
- Fairness: a continuously requesting agent is served within 3 tenures of the current holder.
- Other requesters' REQ bits are ignored during GRANT. Only the holder's bit is sampled.
- MAX_HOLD=1: every grant lasts 1 cycle and strict rotation applies.
- Reset mid-grant: GNT drops immediately (asynchronously) and PRI returns to 0.
- No X outputs in any state.

Optional Feature:
Macro ARB_LOCK_EN.
- Defined: adds input port LOCK (1 bit, after REQ). While in GRANT with LOCK=1 and REQ[GNT_ID]=1, the MAX_HOLD limit is ignored; the count saturates at MAX_HOLD-1. Release still occurs on REQ drop or EN=0. Deasserting LOCK once the count is at or above the limit releases at the next edge.
- Undefined: no LOCK port; the hold limit is always enforced.

Decomposition:
- Shared package arb_pkg: NUM_REQ=4, ID_W=2, state encoding (IDLE=2'd0, GRANT=2'd1, TURN=2'd2), onehot-from-ID helper function.
- One sub-module, rr_pick4: combinational rotating priority picker.
  - Inputs: REQ[3:0], PRI[1:0].
  - Outputs: WIN_ID[1:0], WIN_VALID.
  - Built from rotate, fixed priority encode, and un-rotate.
- The top level holds the FSM, counter and PRI register.

Test Plan:
1. RST=1 asserted between clock edges while GNT=0100 -> GNT=0000, BUSY=0 without waiting for an edge; after release, REQ=1111 -> first grant goes to requester 0 (GNT=0001).
2. EN=1, REQ=0010 from cycle 0 -> cycle 1 GNT=0010, GNT_ID=01, BUSY=1; REQ drops at cycle 4 -> GNT=0000 at cycle 5; PRI=2.
3. REQ=1111 held, MAX_HOLD=8 -> grant sequence 0,1,2,3,0, each for exactly 8 cycles, separated by one GNT=0000 cycle.
4. GNT=1000 active, EN driven 0 -> GNT=0000 at the next edge, state TURN then IDLE; REQ=1111 makes no new grant until EN=1, then GNT=0001 (PRI wrapped 3->0).
5. MAX_HOLD=1, REQ=0101 held -> GNT alternates 0001, 0000, 0100, 0000, 0001, ...
6. (ARB_LOCK_EN) REQ=0001, LOCK=1 for 20 cycles -> GNT=0001 held for all 20 cycles; LOCK=0 -> release at the next edge.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the rr_arbiter4 slice: requester count, ID width,
// FSM state encoding and a one-hot-from-ID helper.
package arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

   function automatic logic [NUM_REQ-1:0] onehot(
      input logic [ID_W-1:0] id
   );
      logic [NUM_REQ-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters (master) and arbiter (slave).
// EN/REQ[/LOCK] in, GNT/GNT_ID/BUSY out; LOCK exists only with ARB_LOCK_EN.
interface rr_arbiter4_if;
   import arb_pkg::*;
   logic                EN;
   logic [NUM_REQ-1:0]  REQ;
`ifdef ARB_LOCK_EN
   logic                LOCK;
`endif
   logic [NUM_REQ-1:0]  GNT;
   logic [ID_W-1:0]     GNT_ID;
   logic                BUSY;

`ifdef ARB_LOCK_EN
   modport master (output EN, REQ, LOCK, input GNT, GNT_ID, BUSY);
   modport slave  (input EN, REQ, LOCK, output GNT, GNT_ID, BUSY);
`else
   modport master (output EN, REQ, input GNT, GNT_ID, BUSY);
   modport slave  (input EN, REQ, output GNT, GNT_ID, BUSY);
`endif
endinterface

// File: rtl/rr_pick4.sv
// Rotating-priority picker: REQ[3:0], PRI[1:0] in; WIN_ID[1:0], WIN_VALID out.
// Rotate so PRI lands at bit 0, fixed-priority encode, then un-rotate.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] REQ,
   input  logic [ID_W-1:0]    PRI,
   output logic [ID_W-1:0]    WIN_ID,
   output logic               WIN_VALID
);
   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [ID_W-1:0]      enc;

   always_comb begin
      dbl = {REQ, REQ};
      rot = dbl[PRI +: NUM_REQ];
      enc = '0;
      // descending scan so the lowest set bit wins
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) enc = ID_W'(i);
      end
      // 2-bit add wraps modulo 4
      WIN_ID    = enc + PRI;
      WIN_VALID = |REQ;
   end
endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold limit and one-cycle turnaround.
// Ports: CLK, RST (async active-high), arb (slave: EN, REQ, GNT, GNT_ID, BUSY).
// Optional macro ARB_LOCK_EN adds LOCK, which suspends the hold limit.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input logic          CLK,
   input logic          RST,
   rr_arbiter4_if.slave arb
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

   logic [1:0]         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]    pri_q, pri_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [ID_W-1:0]    win_id;
   logic               win_valid;
   logic               at_limit;
   logic               hold_over;
   logic               rel;

   rr_pick4 u_pick (
      .REQ       (arb.REQ),
      .PRI       (pri_q),
      .WIN_ID    (win_id),
      .WIN_VALID (win_valid)
   );

   // >= rather than == so a lock-extended tenure releases on unlock
   assign at_limit = (cnt_q >= LIMIT);

`ifdef ARB_LOCK_EN
   assign hold_over = at_limit && !arb.LOCK;
`else
   assign hold_over = at_limit;
`endif

   assign rel = !arb.REQ[gnt_id_q] || !arb.EN || hold_over;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      pri_d    = pri_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE, ST_TURN: begin
            if (arb.EN && win_valid) begin
               state_d  = ST_GRANT;
               gnt_d    = onehot(win_id);
               gnt_id_d = win_id;
               cnt_d    = '0;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (rel) begin
               state_d = ST_TURN;
               gnt_d   = '0;
               pri_d   = gnt_id_q + 1'b1;
            end else if (!at_limit) begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         pri_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         pri_q    <= pri_d;
         cnt_q    <= cnt_d;
      end
   end

   assign arb.GNT    = gnt_q;
   assign arb.GNT_ID = gnt_id_q;
   assign arb.BUSY   = |gnt_q;
endmodule
